// File: rtl/keccak_padder_multi_if.sv
// Handshake bundle between the message source / permutation and the multi-rate Keccak padder.
// The padder uses the slave view; the driving side uses the master view.
interface keccak_padder_multi_if #(
    parameter int unsigned MAX_WORDS = 21
) ();
    logic [63:0]             in;
    logic                    in_ready;
    logic                    is_last;
    logic [2:0]              byte_num;
    logic [1:0]              mode;
    logic [4:0]              rate_words;
    logic                    buffer_full;
    logic [64*MAX_WORDS-1:0] out;
    logic                    out_ready;
    logic                    out_last;
    logic                    f_ack;

    modport master (
        output in, in_ready, is_last, byte_num, mode, rate_words, f_ack,
        input  buffer_full, out, out_ready, out_last
    );

    modport slave (
        input  in, in_ready, is_last, byte_num, mode, rate_words, f_ack,
        output buffer_full, out, out_ready, out_last
    );
endinterface

// File: rtl/keccak_padder_multi.sv
// Multi-rate Keccak/SHA3/SHAKE padder: packs 64-bit message words into a rate-sized block,
// appends the domain suffix and the final 0x80 bit, and holds each block until acknowledged.
module keccak_padder_multi #(
    parameter int unsigned MAX_WORDS = 21
) (
    input logic                    clk,
    input logic                    reset,
    keccak_padder_multi_if.slave   bus
);
    localparam logic [4:0] MaxRate = 5'(MAX_WORDS);

    typedef enum logic [1:0] {StAbsorb, StPad, StFull} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] words_q [MAX_WORDS];
    logic        out_ready_q;
    logic        out_last_q;
    logic        buffer_full_q;
    logic [1:0]  mode_q;
    logic [4:0]  rate_q;
    logic        new_msg_q;

    logic [4:0]  req_rate;
    logic [4:0]  eff_rate;
    logic [1:0]  eff_mode;
    logic [7:0]  suffix;
    logic        at_end;
    logic [5:0]  suffix_shift;
    logic [63:0] last_word;
    logic [63:0] end_bit;

    // The first word of a message sees its own mode/rate before they are latched.
    always_comb begin
        req_rate = bus.rate_words;
        if (bus.rate_words == 5'd0 || bus.rate_words > MaxRate) begin
            req_rate = MaxRate;
        end
        eff_rate = new_msg_q ? req_rate : rate_q;
        eff_mode = new_msg_q ? bus.mode : mode_q;
        case (eff_mode)
            2'd1:    suffix = 8'h06;
            2'd2:    suffix = 8'h1F;
            default: suffix = 8'h01;
        endcase
        at_end       = (cnt_q == eff_rate - 5'd1);
        suffix_shift = 6'd56 - {bus.byte_num, 3'b000};
        last_word    = (bus.in & ~({64{1'b1}} >> {bus.byte_num, 3'b000}))
                     | ({56'd0, suffix} << suffix_shift);
        end_bit      = at_end ? 64'h80 : 64'h0;
    end

    always_comb begin
        bus.out = '0;
        for (int k = 0; k < MAX_WORDS; k++) begin
            bus.out[64*(MAX_WORDS-k)-1 -: 64] = words_q[k];
        end
    end

    assign bus.out_ready   = out_ready_q;
    assign bus.out_last    = out_last_q;
    assign bus.buffer_full = buffer_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StAbsorb;
            cnt_q         <= 5'd0;
            out_ready_q   <= 1'b0;
            out_last_q    <= 1'b0;
            buffer_full_q <= 1'b0;
            mode_q        <= 2'd0;
            rate_q        <= MaxRate;
            new_msg_q     <= 1'b1;
            for (int k = 0; k < MAX_WORDS; k++) begin
                words_q[k] <= '0;
            end
        end else begin
            case (state_q)
                StAbsorb: begin
                    if (bus.in_ready && !buffer_full_q) begin
                        if (new_msg_q) begin
                            mode_q    <= bus.mode;
                            rate_q    <= req_rate;
                            new_msg_q <= 1'b0;
                        end
                        words_q[cnt_q] <= bus.is_last ? (last_word | end_bit) : bus.in;
                        cnt_q          <= cnt_q + 5'd1;
                        if (at_end) begin
                            state_q       <= StFull;
                            out_ready_q   <= 1'b1;
                            buffer_full_q <= 1'b1;
                            out_last_q    <= bus.is_last;
                        end else if (bus.is_last) begin
                            state_q <= StPad;
                        end
                    end
                end
                StPad: begin
                    words_q[cnt_q] <= end_bit;
                    cnt_q          <= cnt_q + 5'd1;
                    if (at_end) begin
                        state_q       <= StFull;
                        out_ready_q   <= 1'b1;
                        buffer_full_q <= 1'b1;
                        out_last_q    <= 1'b1;
                    end
                end
                StFull: begin
                    if (bus.f_ack) begin
                        state_q       <= StAbsorb;
                        cnt_q         <= 5'd0;
                        out_ready_q   <= 1'b0;
                        buffer_full_q <= 1'b0;
                        out_last_q    <= 1'b0;
                        // Parameters are relatched only once the final block is consumed.
                        if (out_last_q) begin
                            new_msg_q <= 1'b1;
                        end
                        for (int k = 0; k < MAX_WORDS; k++) begin
                            words_q[k] <= '0;
                        end
                    end
                end
                default: state_q <= StAbsorb;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_padder_multi.sv
// Scoreboard bench for keccak_padder_multi: directed messages push expected blocks, a monitor
// pops and compares each presented block, checks it stays stable, and acknowledges it.
module tb_keccak_padder_multi;
    localparam int unsigned MW = 21;
    localparam int          BW = 64 * MW;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } blk_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keccak_padder_multi_if #(.MAX_WORDS(MW)) bus ();

    keccak_padder_multi #(.MAX_WORDS(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    blk_t          exp_q[$];
    blk_t          cur_exp;
    logic [BW-1:0] eb;
    logic [BW-1:0] held;
    logic          cur_last;
    int            errs      = 0;
    int            checks    = 0;
    int            done_cnt  = 0;
    int            msgs      = 0;
    int            ack_delay = 1;
    int            hold_cyc  = 0;
    bit            seen      = 0;
    bit            stray_ack = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    function automatic logic [63:0] word_of(logic [BW-1:0] b, int k);
        return b[64*(MW-k)-1 -: 64];
    endfunction

    task automatic ew(int k, logic [63:0] v);
        eb[64*(MW-k)-1 -: 64] = v;
    endtask

    task automatic push_exp(bit last);
        blk_t b;
        b.data = eb;
        b.last = last;
        exp_q.push_back(b);
        eb = '0;
    endtask

    function automatic logic [63:0] pat(int m, int i);
        return {8'(m), 8'(i), 48'h0123_4567_89AB};
    endfunction

    // Compare whole blocks word by word; report the first differing word only.
    task automatic chk_block(string nm, logic [BW-1:0] act, logic [BW-1:0] exp_v);
        int bad;
        bad = -1;
        for (int k = MW - 1; k >= 0; k--) begin
            if (word_of(act, k) !== word_of(exp_v, k)) bad = k;
        end
        checks++;
        if (bad >= 0) begin
            errs++;
            $display("FAIL %s word %0d: got %h expected %h", nm, bad,
                     word_of(act, bad), word_of(exp_v, bad));
        end
    endtask

    always @(negedge clk) begin
        bus.f_ack = 1'b0;
        if (reset) begin
            seen = 0;
        end else if (bus.out_ready) begin
            if (!seen) begin
                seen     = 1;
                hold_cyc = 0;
                held     = bus.out;
                cur_last = bus.out_last;
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_block: got block (out_last %0b) expected none",
                             bus.out_last);
                end else begin
                    cur_exp = exp_q.pop_front();
                    chk_block("block_data", bus.out, cur_exp.data);
                    chk("out_last", 64'(bus.out_last), 64'(cur_exp.last));
                end
                chk("buffer_full_in_full", 64'(bus.buffer_full), 64'd1);
            end else begin
                hold_cyc++;
                chk_block("out_stable", bus.out, held);
                chk("out_last_stable", 64'(bus.out_last), 64'(cur_last));
            end
            if (hold_cyc >= ack_delay) begin
                bus.f_ack = 1'b1;
                if (hold_cyc == ack_delay && cur_last) done_cnt++;
            end
        end else begin
            seen      = 0;
            bus.f_ack = stray_ack;
        end
    end

    task automatic drive(logic [63:0] w, bit last, logic [2:0] bn, logic [1:0] md,
                         logic [4:0] rt);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        while (!acc && n < 300) begin
            @(negedge clk);
            bus.in         = w;
            bus.in_ready   = 1'b1;
            bus.is_last    = last;
            bus.byte_num   = bn;
            bus.mode       = md;
            bus.rate_words = rt;
            acc = !bus.buffer_full;
            n++;
        end
        if (!acc) begin
            checks++;
            errs++;
            $display("FAIL send_timeout: got buffer_full stuck expected word accepted");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_ready = 1'b0;
        bus.in       = 64'hDEAD_DEAD_DEAD_DEAD;
        bus.is_last  = 1'b1;
        bus.byte_num = 3'd5;
    endtask

    task automatic finish_msg();
        int n;
        idle();
        msgs++;
        n = 0;
        while (done_cnt < msgs && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < msgs) begin
            checks++;
            errs++;
            $display("FAIL msg_timeout: got %0d final blocks expected %0d", done_cnt, msgs);
            done_cnt = msgs;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        bus.in         = '0;
        bus.in_ready   = 1'b0;
        bus.is_last    = 1'b0;
        bus.byte_num   = '0;
        bus.mode       = '0;
        bus.rate_words = '0;
        eb             = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_out_ready", 64'(bus.out_ready), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_buffer_full", 64'(bus.buffer_full), 64'd0);
        chk("rst_out_zero", 64'(|bus.out), 64'd0);

        // SHA3-256 empty message
        ew(0, 64'h0600_0000_0000_0000);
        ew(16, 64'h0000_0000_0000_0080);
        push_exp(1);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1, 3'd0, 2'd1, 5'd17);
        finish_msg();

        // SHAKE128, last word byte_num 7 in the final slot
        for (int i = 0; i < 20; i++) ew(i, pat(2, i));
        ew(20, 64'h1122_3344_5566_779F);
        push_exp(1);
        for (int i = 0; i < 20; i++) drive(pat(2, i), 0, 3'd0, 2'd2, 5'd21);
        drive(64'h1122_3344_5566_7788, 1, 3'd7, 2'd2, 5'd21);
        finish_msg();

        // SHA3-512, exact-rate message spills padding into a second block
        ack_delay = 3;
        for (int i = 0; i < 9; i++) ew(i, pat(3, i));
        push_exp(0);
        ew(0, 64'h0600_0000_0000_0000);
        ew(8, 64'h0000_0000_0000_0080);
        push_exp(1);
        for (int i = 0; i < 9; i++) drive(pat(3, i), 0, 3'd0, 2'd1, 5'd9);
        drive(64'h5555_5555_5555_5555, 1, 3'd0, 2'd1, 5'd9);
        finish_msg();

        // Keccak rate 18, gapped input, slow ack, stray acks while not full
        ack_delay = 5;
        stray_ack = 1;
        for (int i = 0; i < 18; i++) ew(i, pat(4, i));
        push_exp(0);
        ew(0, pat(4, 18));
        ew(1, 64'hAABB_CC01_0000_0000);
        ew(17, 64'h0000_0000_0000_0080);
        push_exp(1);
        for (int i = 0; i < 19; i++) begin
            drive(pat(4, i), 0, 3'd0, 2'd0, 5'd18);
            idle();
        end
        drive(64'hAABB_CCDD_EEFF_0011, 1, 3'd3, 2'd0, 5'd18);
        finish_msg();
        stray_ack = 0;
        ack_delay = 1;

        // Mode/rate changed mid-message must be ignored
        ew(0, pat(5, 0));
        ew(1, 64'hDEAD_0600_0000_0000);
        ew(12, 64'h0000_0000_0000_0080);
        push_exp(1);
        drive(pat(5, 0), 0, 3'd0, 2'd1, 5'd13);
        drive(64'hDEAD_BEEF_CAFE_F00D, 1, 3'd2, 2'd2, 5'd9);
        finish_msg();

        ew(0, 64'h0123_4567_891F_0000);
        ew(20, 64'h0000_0000_0000_0080);
        push_exp(1);
        drive(64'h0123_4567_89AB_CDEF, 1, 3'd5, 2'd2, 5'd21);
        finish_msg();

        // Rate 0 and reserved mode fall back to MAX_WORDS and 0x01
        ew(0, 64'h0100_0000_0000_0000);
        ew(20, 64'h0000_0000_0000_0080);
        push_exp(1);
        drive(64'h0, 1, 3'd0, 2'd3, 5'd0);
        finish_msg();

        // Rate above MAX_WORDS clamps
        ew(0, pat(6, 0));
        ew(1, 64'h0600_0000_0000_0000);
        ew(20, 64'h0000_0000_0000_0080);
        push_exp(1);
        drive(pat(6, 0), 0, 3'd0, 2'd1, 5'd25);
        drive(64'h7777_7777_7777_7777, 1, 3'd0, 2'd1, 5'd25);
        finish_msg();

        // Final word in slot rate-1 carries suffix and end bit, no extra block
        for (int i = 0; i < 8; i++) ew(i, pat(7, i));
        ew(8, 64'hCAFE_BABE_0600_0080);
        push_exp(1);
        for (int i = 0; i < 8; i++) drive(pat(7, i), 0, 3'd0, 2'd1, 5'd9);
        drive(64'hCAFE_BABE_1234_5678, 1, 3'd4, 2'd1, 5'd9);
        finish_msg();

        // Reset while padding aborts the block
        drive(64'h0, 1, 3'd0, 2'd1, 5'd17);
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("pad_rst_out_ready", 64'(bus.out_ready), 64'd0);
        chk("pad_rst_buffer_full", 64'(bus.buffer_full), 64'd0);
        chk("pad_rst_out_zero", 64'(|bus.out), 64'd0);

        ew(0, pat(8, 0));
        ew(1, 64'h0100_0000_0000_0000);
        ew(8, 64'h0000_0000_0000_0080);
        push_exp(1);
        drive(pat(8, 0), 0, 3'd0, 2'd0, 5'd9);
        drive(64'h0, 1, 3'd0, 2'd0, 5'd9);
        finish_msg();

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/keccak_padder_multi.md
KECCAK_PADDER_MULTI -- requirements
Module: keccak_padder_multi

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 21, meaning the largest rate in 64-bit words (21 = 1344 bits); legal range 9..31.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in  input  64  message word, byte 0 at bits [63:56].
REQ-005 SHALL have port in_ready  input  1  in/is_last/byte_num valid this cycle.
REQ-006 SHALL have port is_last  input  1  current word is the final (partial) word of the message.
REQ-007 SHALL have port byte_num  input  3  count of valid leading bytes in a last word, 0..7.
REQ-008 SHALL have port mode  input  2  suffix select: 0 Keccak 0x01, 1 SHA3 0x06, 2 SHAKE 0x1F, 3 reserved (treated as 0x01).
REQ-009 SHALL have port rate_words  input  5  block rate in words for the message (18/17/13/9 SHA3, 21/17 SHAKE).
REQ-010 SHALL have port buffer_full  output  1  block buffer full, user must stall.
REQ-011 SHALL have port out  output  64*MAX_WORDS  padded block, word k at bits [64*(MAX_WORDS-k)-1 -: 64].
REQ-012 SHALL have port out_ready  output  1  out holds a complete block for the permutation.
REQ-013 SHALL have port out_last  output  1  block in out is the final block of the message.
REQ-014 SHALL have port f_ack  input  1  permutation has consumed out.

Function
REQ-015 SHALL implement states ABSORB, PAD, FULL; ABSORB accepts user words, PAD writes zero words, FULL holds block until f_ack.
REQ-016 SHALL latch mode and rate_words on the first accepted word of each message and ignore them until that message's final block is acknowledged.
REQ-017 SHALL treat latched rate_words of 0 or greater than MAX_WORDS as MAX_WORDS.
REQ-018 SHALL accept a word when state is ABSORB and in_ready is 1 and buffer_full is 0; accepted word is written into word index cnt and cnt increments.
REQ-019 SHALL write a non-last word unmodified.
REQ-020 SHALL, for a last word, keep bytes 0..byte_num-1, place the suffix byte at byte index byte_num, zero the remaining bytes, then go to PAD.
REQ-021 SHALL, in PAD, write one zero word per cycle into index cnt without waiting on in_ready.
REQ-022 SHALL OR 0x80 into bits [7:0] of word rate-1 whenever the padded message ends in that block; with byte_num 7 in word rate-1 this yields suffix|0x80 in the same byte (0x86 for SHA3).
REQ-023 SHALL enter FULL and assert buffer_full and out_ready in the cycle after cnt reaches the latched rate; out_last SHALL be 1 iff the block contains the padding.
REQ-024 SHALL hold out, out_ready and out_last stable in FULL until f_ack.
REQ-025 SHALL, on f_ack in FULL, clear out to zero, clear cnt, deassert out_ready/buffer_full/out_last next cycle, and return to ABSORB (non-final block) or ABSORB with a new message expected (final block).
REQ-026 SHALL ignore f_ack when out_ready is 0.
REQ-027 SHALL ignore in_ready, is_last and byte_num while in PAD or FULL.
REQ-028 SHALL keep out word indices >= latched rate at zero.
REQ-029 SHALL handle a last word with byte_num 0 landing at index 0 of a new block by emitting a block of suffix, zeros and 0x80 only.
REQ-030 SHALL, when the final word fills the block exactly to index rate-1, place suffix and 0x80 in that block with no extra block.

Reset
REQ-031 SHALL, on reset, set state ABSORB, cnt 0, out all zero, out_ready 0, out_last 0, buffer_full 0, latched mode 0, latched rate MAX_WORDS.
REQ-032 SHALL let reset override f_ack, in_ready and any in-progress block or padding.

Verification
REQ-033 SHA3-256 (mode 1, rate 17), empty message (is_last, byte_num 0) -> one block, word0 = 0x0600000000000000, word16 = 0x0000000000000080, words 17..20 zero, out_last 1.
REQ-034 SHAKE128 (mode 2, rate 21), 20 full words then last byte_num 7 -> word20 low byte 0x9F, out_last 1, single block.
REQ-035 SHA3-512 (mode 1, rate 9), 9 full words then last byte_num 0 -> first block unpadded (out_last 0), stalled with buffer_full; after f_ack second block word0 = 0x06..., word8 = 0x...80.
REQ-036 Keccak (mode 0, rate 18) with in_ready toggling every cycle and f_ack delayed 5 cycles -> out stable during FULL, no word lost or duplicated.
REQ-037 Two back-to-back messages with different mode/rate -> each uses its own latched parameters; mode change mid-message has no effect.
REQ-038 Reset asserted in PAD -> next cycle out zero, out_ready 0, new message absorbs from index 0.
